fifo_dpram_ctrl: RTL and testbench
==================================

Name: fifo_dpram_ctrl

Overview:
- Synchronous FIFO controller that turns the 64x8 true dual-port RAM (true_dpram_sclk) into a single-clock FIFO buffer for the PCIe lane datapath.
- RAM port A is the write side and port B is the read side.
- The block owns the pointers, the occupancy count, the status flags and the sticky error flags; the RAM stays an external instance.
- Sits between the lane producer (push side) and the lane consumer (pop side).

Parameters:
- DATA_W, 8, data width; matches RAM data_a/data_b/q_a/q_b.
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.
- AF_TH, 56, almost_full asserted when count >= AF_TH.
- AE_TH, 8, almost_empty asserted when count <= AE_TH.

Ports:
- clk  in  1  single clock; shared with RAM clk.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of pointers and count; error flags are kept.
- push  in  1  write request.
- push_data  in  DATA_W  write data.
- pop  in  1  read request.
- pop_data  out  DATA_W  read data; valid only when pop_valid=1.
- pop_valid  out  1  pop_data valid; one cycle after an accepted pop.
- full  out  1  count == 64.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  ADDR_W+1  occupancy, 0..64.
- overflow_err  out  1  sticky; set by push while full.
- underflow_err  out  1  sticky; set by pop while empty.
- ram_data_a  out  DATA_W  to RAM data_a.
- ram_addr_a  out  ADDR_W  to RAM addr_a.
- ram_we_a  out  1  to RAM we_a.
- ram_data_b  out  DATA_W  to RAM data_b; tied 0.
- ram_addr_b  out  ADDR_W  to RAM addr_b.
- ram_we_b  out  1  to RAM we_b; tied 0.
- ram_q_b  in  DATA_W  from RAM q_b; registered read, 1-cycle latency.

Behaviour:
- Acceptance:
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - Both are evaluated against registered flags; a push while full is rejected even if a pop is accepted in the same cycle.
- Write path:
  - ram_we_a = push_acc & ~reset & ~flush, combinational.
  - ram_addr_a = wptr; ram_data_a = push_data.
  - wptr increments on push_acc, modulo 64 (63 -> 0).
- Read path:
  - ram_addr_b = rptr, combinational.
  - On pop_acc, rptr increments modulo 64.
  - pop_valid is registered to 1 on the next edge; pop_data = ram_q_b while pop_valid=1.
  - Back-to-back pops give one word per cycle.
- Hazard: simultaneous push_acc and pop_acc always address different RAM words, because wptr == rptr only when empty or full. No write-through case exists.
- Count and flags:
  - count_next = count + push_acc - pop_acc, registered.
  - Simultaneous push_acc and pop_acc leaves count unchanged.
  - full, empty, almost_full and almost_empty are registered and computed from count_next, so they are consistent with count in every cycle.
- Error flags:
  - overflow_err is set on push & full.
  - underflow_err is set on pop & empty.
  - Both hold until reset; flush does not clear them.
- Reset values:
  - wptr=0, rptr=0, count=0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - pop_valid=0, pop_data=0 (masked), overflow_err=0, underflow_err=0.
- Reset or flush mid-operation:
  - A pop accepted in the cycle before takes priority loss: pop_valid is forced to 0 on the next cycle.
  - Push and pop in the reset/flush cycle are ignored.
  - RAM contents are not cleared; stale words are unreachable.
- flush vs reset: flush has the same effect as reset on pointers, count, flags and pop_valid; reset has priority over flush.

Optional Feature:
- Macro FIFO_WATERMARK_EN.
- When defined:
  - Adds output peak_count (ADDR_W+1 bits), a registered maximum of count since reset.
  - peak_count is updated whenever count_next > peak_count.
  - Cleared by reset, not by flush.
- When undefined: the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop 3 back-to-back -> pop_valid high for 3 cycles starting 1 cycle after the first pop, pop_data 0x11,0x22,0x33; count 3->0; empty=1 at end.
- Push 64 words 0x00..0x3F -> full=1 and count=64 after the 64th. Push 0xAA -> rejected, overflow_err=1, no RAM write. Pop 64 -> data 0x00..0x3F in order.
- Wrap-around: push 40, pop 40, push 40, pop 40 with data = index -> correct order across the 63->0 wrap; almost_empty/almost_full toggle at count 8/9 and 55/56.
- Simultaneous push and pop at count=5 for 10 cycles -> count stays 5, FIFO order preserved. Pop at empty -> underflow_err=1, pop_valid stays 0.
- Assert flush at count=20 in the cycle after a pop -> next cycle pop_valid=0, count=0, empty=1, error flags unchanged. Then push 0x5A, pop -> 0x5A returned.
- FIFO_WATERMARK_EN: push 30, pop 10, push 5 -> peak_count=30; then reset -> peak_count=0.

Source files
------------

// File: rtl/fifo_dpram_ctrl.sv
// fifo_dpram_ctrl: single-clock FIFO controller wrapped around an external
// 64x8 true dual-port RAM (port A = write side, port B = read side).
// Owns the pointers, the occupancy count, the status flags and the sticky
// error flags. The RAM read on port B is registered, so pop data appears
// one cycle after an accepted pop, alongside pop_valid_o.
// Optional feature macro: FIFO_WATERMARK_EN adds peak_count_o, the highest
// occupancy seen since the last reset.
module fifo_dpram_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned AF_TH  = 56,
    parameter int unsigned AE_TH  = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              pop_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_err_o,
    output logic              underflow_err_o,
`ifdef FIFO_WATERMARK_EN
    output logic [ADDR_W:0]   peak_count_o,
`endif
    output logic [DATA_W-1:0] ram_data_a_o,
    output logic [ADDR_W-1:0] ram_addr_a_o,
    output logic              ram_we_a_o,
    output logic [DATA_W-1:0] ram_data_b_o,
    output logic [ADDR_W-1:0] ram_addr_b_o,
    output logic              ram_we_b_o,
    input  logic [DATA_W-1:0] ram_q_b_i
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              afull_q, afull_d, aempty_q, aempty_d;
    logic              pvld_q, pvld_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push_acc, pop_acc, clr;

    // Acceptance uses the registered flags only; a push while full is
    // refused even when a pop frees a slot in the same cycle.
    assign push_acc = push_i & ~full_q;
    assign pop_acc  = pop_i & ~empty_q;
    assign clr      = reset_i | flush_i;

    // RAM hookup: port A writes at wptr, port B reads at rptr. Pointers only
    // coincide when empty or full, so a concurrent write and read never hit
    // the same word.
    assign ram_we_a_o   = push_acc & ~clr;
    assign ram_addr_a_o = wptr_q;
    assign ram_data_a_o = push_data_i;
    assign ram_addr_b_o = rptr_q;
    assign ram_data_b_o = '0;
    assign ram_we_b_o   = 1'b0;

    assign pop_data_o      = pvld_q ? ram_q_b_i : '0;
    assign pop_valid_o     = pvld_q;
    assign count_o         = count_q;
    assign full_o          = full_q;
    assign empty_o         = empty_q;
    assign almost_full_o   = afull_q;
    assign almost_empty_o  = aempty_q;
    assign overflow_err_o  = ovf_q;
    assign underflow_err_o = unf_q;

    // Next-state: pointers, count, flags derived from the next count, and
    // sticky errors; flush behaves like reset except for the error flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        pvld_d  = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_acc) wptr_d = wptr_q + ADDR_W'(1);
            if (pop_acc)  rptr_d = rptr_q + ADDR_W'(1);
            count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
            pvld_d  = pop_acc;
            ovf_d   = ovf_q | (push_i & full_q);
            unf_d   = unf_q | (pop_i & empty_q);
        end
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_W'(AF_TH));
        aempty_d = (count_d <= CNT_W'(AE_TH));
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            pvld_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            pvld_q   <= pvld_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef FIFO_WATERMARK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    assign peak_count_o = peak_q;

    // High-water mark follows the next count; flush drives count to zero so
    // it never lowers the mark.
    always_comb begin
        peak_d = peak_q;
        if (count_d > peak_q) peak_d = count_d;
    end

    // Watermark register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) peak_q <= '0;
        else         peak_q <= peak_d;
    end
`endif

endmodule

// File: tb/tb_fifo_dpram_ctrl.sv
// Directed bench for fifo_dpram_ctrl with a behavioural 64x8 dual-port RAM
// (registered port-B read) hooked to the controller's RAM ports.
`timescale 1ns/1ps
module tb_fifo_dpram_ctrl;

    logic       clk = 1'b0;
    logic       reset, flush, push, pop;
    logic [7:0] push_data;
    logic [7:0] pop_data;
    logic       pop_valid, full, empty, afull, aempty, ovf, unf;
    logic [6:0] count;
    logic [7:0] ram_data_a, ram_data_b, ram_q_b;
    logic [5:0] ram_addr_a, ram_addr_b;
    logic       ram_we_a, ram_we_b;
`ifdef FIFO_WATERMARK_EN
    logic [6:0] peak;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_dpram_ctrl dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .push_i(push), .push_data_i(push_data), .pop_i(pop),
        .pop_data_o(pop_data), .pop_valid_o(pop_valid),
        .full_o(full), .empty_o(empty),
        .almost_full_o(afull), .almost_empty_o(aempty),
        .count_o(count), .overflow_err_o(ovf), .underflow_err_o(unf),
`ifdef FIFO_WATERMARK_EN
        .peak_count_o(peak),
`endif
        .ram_data_a_o(ram_data_a), .ram_addr_a_o(ram_addr_a), .ram_we_a_o(ram_we_a),
        .ram_data_b_o(ram_data_b), .ram_addr_b_o(ram_addr_b), .ram_we_b_o(ram_we_b),
        .ram_q_b_i(ram_q_b)
    );

    // Behavioural RAM: port A writes, port B reads with one cycle latency.
    logic [7:0] mem [64];
    always_ff @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s mismatch: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request inputs; outputs are then read 1ns
    // after the edge.
    task automatic cyc(input logic ps, input logic [7:0] pd, input logic pp);
        push = ps; push_data = pd; pop = pp;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
        cyc(0, 0, 0); cyc(0, 0, 0);
        reset = 1'b0;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", aempty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_pvld", pop_valid, 0);
        chk("rst_pdata", pop_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        chk("rst_we_b", ram_we_b, 0);
        chk("rst_data_b", ram_data_b, 0);

        // Three pushes, three back-to-back pops
        cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
        chk("t1_count3", count, 3);
        chk("t1_empty3", empty, 0);
        cyc(0, 0, 1);
        chk("t1_pvld0", pop_valid, 1); chk("t1_pd0", pop_data, 8'h11); chk("t1_cnt0", count, 2);
        cyc(0, 0, 1);
        chk("t1_pvld1", pop_valid, 1); chk("t1_pd1", pop_data, 8'h22); chk("t1_cnt1", count, 1);
        cyc(0, 0, 1);
        chk("t1_pvld2", pop_valid, 1); chk("t1_pd2", pop_data, 8'h33); chk("t1_cnt2", count, 0);
        chk("t1_empty", empty, 1);
        cyc(0, 0, 0);
        chk("t1_pvld_off", pop_valid, 0);
        chk("t1_pdata_mask", pop_data, 0);

        // Fill to 64, watch almost flags at the thresholds
        for (int i = 0; i < 64; i++) begin
            cyc(1, 8'(i), 0);
            chk($sformatf("fill_cnt%0d", i), count, i + 1);
            chk($sformatf("fill_ae%0d", i), aempty, (i + 1) <= 8);
            chk($sformatf("fill_af%0d", i), afull, (i + 1) >= 56);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 64);
        // Push while full: no RAM write, overflow sticky
        push = 1'b1; push_data = 8'hAA; #1;
        chk("ovf_we_a", ram_we_a, 0);
        @(posedge clk); #1; push = 1'b0;
        chk("ovf_err", ovf, 1);
        chk("ovf_count", count, 64);
        for (int i = 0; i < 64; i++) begin
            cyc(0, 0, 1);
            chk($sformatf("drain_pd%0d", i), pop_data, i);
            chk($sformatf("drain_pv%0d", i), pop_valid, 1);
        end
        chk("drain_empty", empty, 1);

        // Wrap-around: pointers start at 3, second pass crosses 63 -> 0
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40; i++) cyc(1, 8'(i + 64 * r), 0);
            chk($sformatf("wrap_cnt_r%0d", r), count, 40);
            for (int i = 0; i < 40; i++) begin
                cyc(0, 0, 1);
                chk($sformatf("wrap_pd_r%0d_%0d", r, i), pop_data, i + 64 * r);
                chk($sformatf("wrap_ae_r%0d_%0d", r, i), aempty, (39 - i) <= 8);
            end
        end
        chk("wrap_empty", empty, 1);

        // Simultaneous push and pop at count 5
        for (int i = 0; i < 5; i++) cyc(1, 8'h80 + 8'(i), 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1, 8'h90 + 8'(k), 1);
            chk($sformatf("sim_cnt%0d", k), count, 5);
            chk($sformatf("sim_pd%0d", k), pop_data, (k < 5) ? 8'h80 + k : 8'h90 + k - 5);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1);
            chk($sformatf("sim_tail%0d", k), pop_data, 8'h95 + k);
        end
        chk("sim_empty", empty, 1);
        cyc(0, 0, 1);
        chk("unf_err", unf, 1);
        chk("unf_pvld", pop_valid, 0);
        chk("unf_count", count, 0);

        // Flush at count 20, the cycle after a pop
        for (int i = 0; i < 21; i++) cyc(1, 8'h40 + 8'(i), 0);
        cyc(0, 0, 1);
        chk("fl_pre_cnt", count, 20);
        chk("fl_pre_pd", pop_data, 8'h40);
        flush = 1'b1; push = 1'b1; push_data = 8'hC3; pop = 1'b1; #1;
        chk("fl_we_a", ram_we_a, 0);
        @(posedge clk); #1;
        flush = 1'b0; push = 1'b0; pop = 1'b0;
        chk("fl_pvld", pop_valid, 0);
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_aempty", aempty, 1);
        chk("fl_ovf_kept", ovf, 1);
        chk("fl_unf_kept", unf, 1);
        cyc(1, 8'h5A, 0);
        chk("fl_cnt1", count, 1);
        cyc(0, 0, 1);
        chk("fl_pvld_5a", pop_valid, 1);
        chk("fl_pd_5a", pop_data, 8'h5A);

`ifdef FIFO_WATERMARK_EN
        chk("wm_peak64", peak, 64);
        reset = 1'b1; cyc(0, 0, 0); reset = 1'b0;
        chk("wm_rst0", peak, 0);
        for (int i = 0; i < 30; i++) cyc(1, 8'(i), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 8'(i), 0);
        chk("wm_count25", count, 25);
        chk("wm_peak30", peak, 30);
        flush = 1'b1; cyc(0, 0, 0); flush = 1'b0;
        chk("wm_flush_keep", peak, 30);
        reset = 1'b1; cyc(0, 0, 0); reset = 1'b0;
        chk("wm_rst_clr", peak, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
